// File: rtl/rr_arbiter_4_encoded.sv
// Four-way round-robin arbiter with a one-hot grant, its 2-bit encoded index,
// and forced rotation once an owner has held the resource for MAX_HOLD cycles.
module rr_arbiter_4_encoded #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant_lines,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]        grant_lines_q, grant_lines_d;
    logic [1:0]        grant_idx_q, grant_idx_d;
    logic              grant_valid_q, grant_valid_d;
    logic              timeout_q, timeout_d;

    logic [1:0]        winner_c;
    logic              found_c;

    // First requester found scanning upward from ptr, wrapping modulo 4.
    always_comb begin
        winner_c = 2'b00;
        found_c  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!found_c && req[ptr_q + 2'(k)]) begin
                winner_c = ptr_q + 2'(k);
                found_c  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        grant_lines_d = grant_lines_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (found_c) begin
                    state_d       = GRANT;
                    grant_lines_d = 4'b0001 << winner_c;
                    grant_idx_d   = winner_c;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = HOLD_W'(1);
                end
            end
            GRANT: begin
                // Release takes precedence over expiry, so timeout only fires on a held request.
                if (!req[grant_idx_q] || (hold_cnt_q == HOLD_W'(MAX_HOLD))) begin
                    state_d       = IDLE;
                    grant_lines_d = 4'b0000;
                    grant_idx_d   = 2'b00;
                    grant_valid_d = 1'b0;
                    hold_cnt_d    = '0;
                    ptr_d         = grant_idx_q + 2'd1;
                    timeout_d     = req[grant_idx_q];
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= 2'b00;
            hold_cnt_q    <= '0;
            grant_lines_q <= 4'b0000;
            grant_idx_q   <= 2'b00;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_lines_q <= grant_lines_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign grant_lines = grant_lines_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4_encoded.sv
// Self-checking bench for rr_arbiter_4_encoded: directed scenarios plus
// random request traffic compared against a cycle-level behavioural model.
module tb_rr_arbiter_4_encoded;

    localparam int unsigned MAXH = 8;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant_lines;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: who owns the resource, for how long, and who is next in line.
    bit m_busy;
    int m_owner;
    int m_hold;
    int m_ptr;
    bit m_to;

    rr_arbiter_4_encoded #(.MAX_HOLD(MAXH), .HOLD_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant_lines (grant_lines),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] dut_vec;
    assign dut_vec = {grant_lines, grant_idx, grant_valid, timeout};

    function automatic logic [7:0] exp_vec();
        logic [3:0] l;
        logic [1:0] i;
        l = m_busy ? 4'(1 << m_owner) : 4'b0000;
        i = m_busy ? 2'(m_owner) : 2'b00;
        return {l, i, m_busy, m_to};
    endfunction

    task automatic model_update(input logic rst, input logic [3:0] r);
        if (rst) begin
            m_busy = 0; m_owner = 0; m_hold = 0; m_ptr = 0; m_to = 0;
        end else if (!m_busy) begin
            m_to = 0;
            for (int k = 0; k < 4; k++) begin
                if (!m_busy && r[(m_ptr + k) % 4]) begin
                    m_busy  = 1;
                    m_owner = (m_ptr + k) % 4;
                    m_hold  = 1;
                end
            end
        end else if (!r[m_owner]) begin
            m_busy = 0; m_ptr = (m_owner + 1) % 4; m_to = 0; m_hold = 0;
        end else if (m_hold == int'(MAXH)) begin
            m_busy = 0; m_ptr = (m_owner + 1) % 4; m_to = 1; m_hold = 0;
        end else begin
            m_hold++;
            m_to = 0;
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] r);
        reset = rst;
        req   = r;
        @(posedge clk);
        model_update(rst, r);
        #1;
    endtask

    // Structural properties of the outputs, every cycle.
    always @(negedge clk) begin
        logic [1:0] enc;
        enc = 2'b00;
        for (int i = 0; i < 4; i++) if (grant_lines[i]) enc = 2'(i);
        checks++;
        if ($countones(grant_lines) > 1) begin
            errors++;
            $display("FAIL inv_onehot: grant_lines=%b required one-hot or zero", grant_lines);
        end
        checks++;
        if (grant_idx !== enc) begin
            errors++;
            $display("FAIL inv_idx: grant_idx=%b required %b for grant_lines=%b", grant_idx, enc, grant_lines);
        end
        checks++;
        if (grant_valid !== (|grant_lines)) begin
            errors++;
            $display("FAIL inv_valid: grant_valid=%b required %b", grant_valid, |grant_lines);
        end
    end

    task automatic test_reset();
        step(1'b1, 4'b0000);
        checks++;
        if (dut_vec !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 00", dut_vec);
        end
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 4'b0000);
            checks++;
            if (dut_vec !== exp_vec() || dut.ptr_q !== 2'b00) begin
                errors++;
                $display("FAIL reset_idle c%0d: got %h ptr %0d required %h ptr 0", c, dut_vec, dut.ptr_q, exp_vec());
            end
        end
    endtask

    task automatic test_release_order();
        step(1'b1, 4'b0000);
        step(1'b0, 4'b1010);
        checks++;
        if (dut_vec !== {4'b0010, 2'b01, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL release_grant1: got %h required %h", dut_vec, {4'b0010, 2'b01, 1'b1, 1'b0});
        end
        step(1'b0, 4'b1000);
        checks++;
        if (grant_valid !== 1'b0 || dut.ptr_q !== 2'd2) begin
            errors++;
            $display("FAIL release_idle: valid %b ptr %0d required valid 0 ptr 2", grant_valid, dut.ptr_q);
        end
        step(1'b0, 4'b1000);
        checks++;
        if (dut_vec !== {4'b1000, 2'b11, 1'b1, 1'b0} || dut.ptr_q !== 2'd2) begin
            errors++;
            $display("FAIL release_grant3: got %h ptr %0d required %h ptr 2", dut_vec, dut.ptr_q, {4'b1000, 2'b11, 1'b1, 1'b0});
        end
    endtask

    task automatic test_timeout();
        int gcyc;
        int tpulse;
        gcyc = 0;
        tpulse = 0;
        step(1'b1, 4'b0000);
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 4'b0100);
            if (c < 9 && grant_valid) gcyc++;
            if (timeout) tpulse++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL timeout_seq c%0d: got %h required %h", c, dut_vec, exp_vec());
            end
        end
        checks++;
        if (gcyc != int'(MAXH) || tpulse != 1) begin
            errors++;
            $display("FAIL timeout_len: grant cycles %0d pulses %0d required %0d and 1", gcyc, tpulse, MAXH);
        end
        checks++;
        if (grant_lines !== 4'b0100) begin
            errors++;
            $display("FAIL timeout_regrant: got %b required 0100", grant_lines);
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [3:0] r;
        step(1'b1, 4'b0000);
        for (int c = 0; c < 20 && order.size() < 5; c++) begin
            r = 4'b1111;
            if (m_busy) r[m_owner] = 1'b0;
            step(1'b0, r);
            if (grant_valid) order.push_back(int'(grant_idx));
        end
        checks++;
        if (order.size() != 5) begin
            errors++;
            $display("FAIL rr_count: got %0d grants required 5", order.size());
        end
        for (int i = 0; i < order.size() && i < 5; i++) begin
            checks++;
            if (order[i] != exp_order[i]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d required %0d", i, order[i], exp_order[i]);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b0000);
        for (int c = 0; c < 3; c++) step(1'b0, 4'b0100);
        step(1'b1, 4'b0100);
        checks++;
        if (dut_vec !== 8'h00) begin
            errors++;
            $display("FAIL midreset_clear: got %h required 00", dut_vec);
        end
        step(1'b0, 4'b0100);
        checks++;
        if (dut_vec !== {4'b0100, 2'b10, 1'b1, 1'b0} || dut.ptr_q !== 2'd0) begin
            errors++;
            $display("FAIL midreset_restart: got %h ptr %0d required %h ptr 0", dut_vec, dut.ptr_q, {4'b0100, 2'b10, 1'b1, 1'b0});
        end
    endtask

    task automatic test_release_at_expiry();
        step(1'b1, 4'b0000);
        for (int c = 0; c < int'(MAXH); c++) step(1'b0, 4'b0001);
        step(1'b0, 4'b0000);
        checks++;
        if (dut_vec !== 8'h00 || dut.ptr_q !== 2'd1) begin
            errors++;
            $display("FAIL release_vs_expiry: got %h ptr %0d required 00 ptr 1", dut_vec, dut.ptr_q);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic rst;
        r = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 5) == 0) r = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 59) == 0);
            step(rst, r);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random c%0d req %b: got %h required %h", c, r, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        m_busy = 0; m_owner = 0; m_hold = 0; m_ptr = 0; m_to = 0;
        test_reset();
        test_release_order();
        test_timeout();
        test_round_robin();
        test_reset_mid_grant();
        test_release_at_expiry();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4_encoded.md
Name: rr_arbiter_4_encoded

Overview:
- Round-robin arbiter sharing one resource among 4 requesters.
- Drives a one-hot grant vector and its 2-bit encoded index, using the 4-to-2 encoding convention: line 3 → 2'b11, line 0 → 2'b00.
- Sits in front of the shared encoder datapath and selects which request line owns it.
- Adds fairness (rotating priority) and a bounded hold time (forced rotation after MAX_HOLD cycles).

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one requester may hold the grant; legal range 1..255.
- HOLD_W, 8, width of the internal hold counter; must satisfy 2**HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request lines; req[i]=1 means requester i wants the resource; level-sensitive.
- grant_lines  output  4  one-hot grant, all zero when no grant; registered.
- grant_idx  output  2  encoded index of the granted line; 2'b00 when no grant; registered.
- grant_valid  output  1  1 while any grant is active; equals |grant_lines.
- timeout  output  1  one-cycle pulse on the cycle a grant is revoked by MAX_HOLD expiry.

Behaviour:
- Reset, sampled on rising clk with reset=1, forces:
  - state=IDLE, ptr=2'b00, hold_cnt=0
  - grant_lines=4'b0000, grant_idx=2'b00, grant_valid=0, timeout=0
- Reset overrides everything, including mid-grant: the grant drops on the next edge and no timeout pulse is produced.
- State encoding: IDLE, GRANT (2 states). The internal register ptr[1:0] holds the highest-priority index.
- IDLE:
  - If req==0, stay in IDLE; outputs remain zero.
  - Else select winner w = first i in order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with req[i]=1.
  - Next edge: state=GRANT, grant_lines=1<<w, grant_idx=w, hold_cnt=1.
  - Latency: req asserted before edge N → grant visible after edge N (one cycle).
- GRANT, with owner o:
  - Release: if req[o]==0 at an edge → state=IDLE, grants cleared, ptr=o+1 mod 4, timeout=0.
  - Expiry: else if hold_cnt==MAX_HOLD → state=IDLE, grants cleared, ptr=o+1 mod 4, timeout=1 for exactly that one cycle.
  - Otherwise stay in GRANT; hold_cnt increments; grant outputs unchanged.
  - Requests from other lines while in GRANT are ignored. No preemption.
- Every grant ends with at least one idle cycle (grant_valid=0) before the next grant.
- hold_cnt and MAX_HOLD boundaries:
  - Owner holds at most MAX_HOLD cycles with grant_valid=1.
  - With MAX_HOLD=1 each grant lasts exactly one cycle.
- Fairness: after o releases or times out, o has lowest priority. The same requester is re-granted immediately only if no other line requests.
- ptr wraps 3→0.
- Simultaneous release and expiry on the same edge: release wins, timeout=0.
- Invariants, checked every cycle:
  - grant_lines is one-hot or zero.
  - grant_idx matches the encoding of grant_lines.
  - grant_valid == |grant_lines.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles → grant_lines=0, grant_idx=00, grant_valid=0, ptr=0 throughout.
- From reset, req=4'b1010 held → grant to line 1 (grant_lines=0010, idx=01) one cycle after req. Drop req[1] → one idle cycle. Then grant to line 3 (1000, idx=11); ptr=2 during that grant.
- MAX_HOLD=8, req=4'b0100 held constantly → grant_lines=0100 for exactly 8 cycles. timeout pulses once at revocation, then 1 idle cycle, then line 2 re-granted (sole requester).
- req=4'b1111 held, each owner drops its req one cycle after being granted → grant order 0,1,2,3,0 with grant_idx 00,01,10,11,00.
- Mid-grant to line 2 with hold_cnt=3, assert reset for 1 cycle → next cycle all outputs zero, timeout=0. After reset released with req=4'b0100, grant to line 2 restarts with ptr=0.
- Owner 0 drops req on the same edge hold_cnt==MAX_HOLD → state IDLE, timeout stays 0, ptr=1.
